// File: rtl/apb_ucpd_pkg.sv
// Shared types and constants for the UCPD multi-message receive buffer.
// Holds the write/read FSM state encodings, the ordered-set width and the
// bit layout of a queued message descriptor {ordset, len, crc_err}.
package apb_ucpd_pkg;

    localparam int unsigned ORDSET_W = 7;

    // Descriptor layout, LSB first: crc_err | len[CNT_W] | ordset[ORDSET_W]
    localparam int unsigned DESC_CRC_OFS = 0;
    localparam int unsigned DESC_LEN_OFS = 1;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WRecv = 2'd1,
        WDrop = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RIdle = 2'd0,
        RData = 2'd1,
        REnd  = 2'd2
    } rd_state_e;

    function automatic int unsigned desc_os_ofs(input int unsigned cnt_w);
        return DESC_LEN_OFS + cnt_w;
    endfunction

    function automatic int unsigned desc_width(input int unsigned cnt_w);
        return ORDSET_W + cnt_w + 1;
    endfunction

endpackage

// File: rtl/apb_ucpd_rx_msgbuf_if.sv
// Signal bundle between the UCPD RX decode path / APB register file and the
// multi-message receive buffer.
//   master : decode side (sop/byte/eop/abort) and firmware side (rxdr_rd, msg_ack, clr)
//   slave  : the buffer, returning head descriptor, RXDR byte and status
interface apb_ucpd_rx_msgbuf_if
    import apb_ucpd_pkg::*;
#(
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned MSG_DEPTH = 4
) ();
    logic                         clr;
    logic                         rx_sop;
    logic [ORDSET_W-1:0]          rx_ordset;
    logic                         rx_byte_vld;
    logic [7:0]                   rx_byte_in;
    logic                         rx_eop;
    logic                         rx_crc_ok;
    logic                         rx_abort;
    logic                         rxdr_rd;
    logic                         msg_ack;
    logic                         msg_avail;
    logic [ORDSET_W-1:0]          msg_ordset;
    logic [CNT_W-1:0]             msg_len;
    logic                         msg_crc_err;
    logic [7:0]                   rx_byte;
    logic                         rxne;
    logic                         msg_end;
    logic                         rx_ovr;
    logic [$clog2(MSG_DEPTH):0]   msg_cnt;

    modport master (
        output clr, rx_sop, rx_ordset, rx_byte_vld, rx_byte_in, rx_eop, rx_crc_ok,
               rx_abort, rxdr_rd, msg_ack,
        input  msg_avail, msg_ordset, msg_len, msg_crc_err, rx_byte, rxne, msg_end,
               rx_ovr, msg_cnt
    );

    modport slave (
        input  clr, rx_sop, rx_ordset, rx_byte_vld, rx_byte_in, rx_eop, rx_crc_ok,
               rx_abort, rxdr_rd, msg_ack,
        output msg_avail, msg_ordset, msg_len, msg_crc_err, rx_byte, rxne, msg_end,
               rx_ovr, msg_cnt
    );
endinterface

// File: rtl/apb_ucpd_rxbuf_desc_fifo.sv
// Synchronous descriptor FIFO (Depth x Width) for queued PD messages.
// Ports: clk_i, rst_ni (async active-low), clr_i (sync flush), push_i/wdata_i,
// pop_i, rdata_o (head entry, valid when !empty_o), full_o, empty_o, cnt_o.
// Pointers carry one extra wrap bit so full/empty need no separate counter.
module apb_ucpd_rxbuf_desc_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 18
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic [Width-1:0]          wdata_i,
    input  logic                      pop_i,
    output logic [Width-1:0]          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(Depth):0]    cnt_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign cnt_o   = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/apb_ucpd_rx_msgbuf.sv
// Multi-message receive buffer between the UCPD RX decode path and RXDR.
// Payload bytes go into a DATA_DEPTH byte ring; each finished frame pushes a
// descriptor {ordset, len, crc_err}. Frames are committed atomically on EOP and
// rolled back on abort / overflow (wr_tmp is rewound to the committed wr_ptr).
// Ports: ic_clk, ic_rst_n (async active-low), bus (slave modport: decode inputs,
// firmware rxdr_rd/msg_ack/clr, head descriptor, RXDR byte, rxne, msg_end,
// sticky rx_ovr, msg_cnt).
// Build option: UCPD_RXBUF_DROP_BAD_EN -- bad-CRC frames are rolled back and
// msg_crc_err is tied 0; otherwise they are committed with msg_crc_err=1.
module apb_ucpd_rx_msgbuf
    import apb_ucpd_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 64,
    parameter int unsigned MSG_DEPTH  = 4,
    parameter int unsigned CNT_W      = 10
) (
    input logic                  ic_clk,
    input logic                  ic_rst_n,
    apb_ucpd_rx_msgbuf_if.slave  bus
);
    localparam int unsigned AW = $clog2(DATA_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = desc_width(CNT_W);
    localparam logic [CNT_W-1:0] LEN_MAX = '1;

    wr_state_e           wr_st_q, wr_st_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d;
    logic [CNT_W-1:0]    wr_len_q, wr_len_d;
    logic [ORDSET_W-1:0] wr_os_q, wr_os_d;
    logic                rx_ovr_q, rx_ovr_d;

    rd_state_e           rd_st_q, rd_st_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    rd_rem_q, rd_rem_d;
    logic [7:0]          rx_byte_q, rx_byte_d;
    logic                rxne_q, rxne_d, msg_end_q, msg_end_d;

    logic [7:0]          mem_q [DATA_DEPTH];
    logic                mem_we, data_full, frame_start;

    logic                desc_push, desc_pop, desc_full, desc_empty, desc_crc_err;
    logic [DW-1:0]       desc_wdata, desc_rdata;
    logic [$clog2(MSG_DEPTH):0] desc_cnt;
    logic                msg_avail;
    logic [CNT_W-1:0]    hd_len;
    logic [ORDSET_W-1:0] hd_os;

    // Full when the in-flight frame has consumed every byte not yet read out.
    assign data_full = (wr_tmp_q[AW] != rd_ptr_q[AW]) &&
                       (wr_tmp_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign desc_wdata = {wr_os_q, wr_len_q, desc_crc_err};
    assign hd_len     = desc_rdata[DESC_LEN_OFS +: CNT_W];
    assign hd_os      = desc_rdata[desc_os_ofs(CNT_W) +: ORDSET_W];
    assign msg_avail  = !desc_empty;

    apb_ucpd_rxbuf_desc_fifo #(
        .Depth (MSG_DEPTH),
        .Width (DW)
    ) u_desc_fifo (
        .clk_i   (ic_clk),
        .rst_ni  (ic_rst_n),
        .clr_i   (bus.clr),
        .push_i  (desc_push),
        .wdata_i (desc_wdata),
        .pop_i   (desc_pop),
        .rdata_o (desc_rdata),
        .full_o  (desc_full),
        .empty_o (desc_empty),
        .cnt_o   (desc_cnt)
    );

    // Write side: decode path into tentative region, commit on EOP.
    always_comb begin
        wr_st_d      = wr_st_q;
        wr_ptr_d     = wr_ptr_q;
        wr_tmp_d     = wr_tmp_q;
        wr_len_d     = wr_len_q;
        wr_os_d      = wr_os_q;
        rx_ovr_d     = rx_ovr_q;
        mem_we       = 1'b0;
        desc_push    = 1'b0;
        desc_crc_err = 1'b0;
        frame_start  = 1'b0;
        unique case (wr_st_q)
            WIdle: frame_start = bus.rx_sop;
            WRecv: begin
                if (bus.rx_sop) begin
                    // New SOP discards the partial frame and restarts in place.
                    frame_start = 1'b1;
                end else if (bus.rx_abort) begin
                    wr_tmp_d = wr_ptr_q;
                    wr_st_d  = WIdle;
                end else if (bus.rx_eop) begin
`ifdef UCPD_RXBUF_DROP_BAD_EN
                    if (bus.rx_crc_ok) begin
                        wr_ptr_d  = wr_tmp_q;
                        desc_push = 1'b1;
                    end else begin
                        wr_tmp_d = wr_ptr_q;
                    end
`else
                    wr_ptr_d     = wr_tmp_q;
                    desc_push    = 1'b1;
                    desc_crc_err = !bus.rx_crc_ok;
`endif
                    wr_st_d = WIdle;
                end else if (bus.rx_byte_vld) begin
                    if (data_full || (wr_len_q == LEN_MAX)) begin
                        wr_tmp_d = wr_ptr_q;
                        rx_ovr_d = 1'b1;
                        wr_st_d  = WDrop;
                    end else begin
                        mem_we   = 1'b1;
                        wr_tmp_d = wr_tmp_q + PW'(1);
                        wr_len_d = wr_len_q + CNT_W'(1);
                    end
                end
            end
            WDrop: if (bus.rx_eop || bus.rx_abort) wr_st_d = WIdle;
            default: wr_st_d = WIdle;
        endcase
        if (frame_start) begin
            wr_tmp_d = wr_ptr_q;
            wr_len_d = '0;
            wr_os_d  = bus.rx_ordset;
            if (desc_full) begin
                rx_ovr_d = 1'b1;
                wr_st_d  = WDrop;
            end else begin
                wr_st_d = WRecv;
            end
        end
        if (bus.clr) begin
            wr_st_d   = WIdle;
            wr_ptr_d  = '0;
            wr_tmp_d  = '0;
            wr_len_d  = '0;
            wr_os_d   = '0;
            rx_ovr_d  = 1'b0;
            mem_we    = 1'b0;
            desc_push = 1'b0;
        end
    end

    // Read side: present head message byte by byte on RXDR.
    always_comb begin
        rd_st_d   = rd_st_q;
        rd_ptr_d  = rd_ptr_q;
        rd_rem_d  = rd_rem_q;
        rx_byte_d = rx_byte_q;
        rxne_d    = rxne_q;
        msg_end_d = msg_end_q;
        desc_pop  = 1'b0;
        if (bus.msg_ack && msg_avail) begin
            // In RIdle the head length has not been loaded into rd_rem yet.
            desc_pop  = 1'b1;
            rd_ptr_d  = rd_ptr_q + PW'((rd_st_q == RIdle) ? hd_len : rd_rem_q);
            rd_rem_d  = '0;
            rxne_d    = 1'b0;
            msg_end_d = 1'b0;
            rd_st_d   = RIdle;
        end else begin
            unique case (rd_st_q)
                RIdle: begin
                    if (msg_avail) begin
                        if (hd_len == '0) begin
                            rd_st_d   = REnd;
                            msg_end_d = 1'b1;
                        end else begin
                            rd_st_d  = RData;
                            rd_rem_d = hd_len;
                        end
                    end
                end
                RData: begin
                    if (!rxne_q) begin
                        rx_byte_d = mem_q[rd_ptr_q[AW-1:0]];
                        rxne_d    = 1'b1;
                    end else if (bus.rxdr_rd) begin
                        rxne_d   = 1'b0;
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        rd_rem_d = rd_rem_q - CNT_W'(1);
                        if (rd_rem_q == CNT_W'(1)) begin
                            rd_st_d   = REnd;
                            msg_end_d = 1'b1;
                        end
                    end
                end
                REnd: ;
                default: rd_st_d = RIdle;
            endcase
        end
        if (bus.clr) begin
            rd_st_d   = RIdle;
            rd_ptr_d  = '0;
            rd_rem_d  = '0;
            rx_byte_d = '0;
            rxne_d    = 1'b0;
            msg_end_d = 1'b0;
            desc_pop  = 1'b0;
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            wr_st_q   <= WIdle;
            wr_ptr_q  <= '0;
            wr_tmp_q  <= '0;
            wr_len_q  <= '0;
            wr_os_q   <= '0;
            rx_ovr_q  <= 1'b0;
            rd_st_q   <= RIdle;
            rd_ptr_q  <= '0;
            rd_rem_q  <= '0;
            rx_byte_q <= '0;
            rxne_q    <= 1'b0;
            msg_end_q <= 1'b0;
        end else begin
            wr_st_q   <= wr_st_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_tmp_q  <= wr_tmp_d;
            wr_len_q  <= wr_len_d;
            wr_os_q   <= wr_os_d;
            rx_ovr_q  <= rx_ovr_d;
            rd_st_q   <= rd_st_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_rem_q  <= rd_rem_d;
            rx_byte_q <= rx_byte_d;
            rxne_q    <= rxne_d;
            msg_end_q <= msg_end_d;
        end
    end

    always_ff @(posedge ic_clk) begin
        if (mem_we) mem_q[wr_tmp_q[AW-1:0]] <= bus.rx_byte_in;
    end

    assign bus.msg_avail  = msg_avail;
    assign bus.msg_ordset = msg_avail ? hd_os : '0;
    assign bus.msg_len    = msg_avail ? hd_len : '0;
`ifdef UCPD_RXBUF_DROP_BAD_EN
    assign bus.msg_crc_err = 1'b0;
`else
    assign bus.msg_crc_err = msg_avail & desc_rdata[DESC_CRC_OFS];
`endif
    assign bus.rx_byte = rx_byte_q;
    assign bus.rxne    = rxne_q;
    assign bus.msg_end = msg_end_q;
    assign bus.rx_ovr  = rx_ovr_q;
    assign bus.msg_cnt = desc_cnt;

endmodule
